// File: rtl/freqchng_pkg.sv
// Shared definitions for the glitch-safe clock-select sequencer: FSM states,
// index limit and the frequency-index to BUFGMUX-select encoding.
package freqchng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [2:0] FREQ_IDX_MAX = 3'd5;

  // bit0 drives the first mux stage, bit1 the second, bit2 the output stage.
  function automatic logic [2:0] freq_encode(input logic [2:0] idx);
    logic [2:0] sel;
    case (idx)
      3'd0: sel = 3'b000;
      3'd1: sel = 3'b001;
      3'd2: sel = 3'b010;
      3'd3: sel = 3'b011;
      3'd4: sel = 3'b100;
      3'd5: sel = 3'b101;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/freqchng_settle_timer.sv
// 8-bit settle countdown: load sets the count, count decrements it, and
// expire flags the last counting cycle (count value 1).
module freqchng_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       count,
  output logic       expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = count && (cnt == 8'd1);

endmodule

// File: rtl/freqchng_ctrl.sv
// Frequency-change controller: walks FREQ_SEL toward the requested encoding
// one bit at a time, holding each step for SETTLE_CYCLES before the next.
module freqchng_ctrl
  import freqchng_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned RESET_FREQ    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_freq,
  output logic       req_ready,
  output logic [2:0] freq_sel,
  output logic [2:0] cur_freq,
  output logic       busy,
  output logic       done,
  output logic       err,
  output state_t     dbg_state
);

  localparam logic [2:0] RESET_IDX   = 3'(RESET_FREQ);
  localparam logic [2:0] RESET_SEL   = freq_encode(RESET_IDX);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state, state_next;
  logic [2:0] target_idx, target_sel;
  logic [2:0] sel_next, diff, step_mask;
  logic       accept, req_bad, timer_load, timer_count, timer_expire;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, nothing is queued.
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_bad   = (req_freq > FREQ_IDX_MAX);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign dbg_state = state;
  assign diff      = freq_sel ^ target_sel;

  always_comb begin
    step_mask = 3'b000;
    if (diff[0])      step_mask = 3'b001;
    else if (diff[1]) step_mask = 3'b010;
    else if (diff[2]) step_mask = 3'b100;
  end

  always_comb begin
    state_next  = state;
    sel_next    = freq_sel;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !req_bad) state_next = ST_STEP;
      end
      ST_STEP: begin
        if (diff != 3'b000) begin
          sel_next   = freq_sel ^ step_mask;
          timer_load = 1'b1;
          state_next = ST_SETTLE;
        end else begin
          state_next = ST_FINISH;
        end
      end
      ST_SETTLE: begin
        timer_count = 1'b1;
        if (timer_expire) state_next = ST_STEP;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      freq_sel   <= RESET_SEL;
      cur_freq   <= RESET_IDX;
      target_idx <= RESET_IDX;
      target_sel <= RESET_SEL;
      err        <= 1'b0;
    end else begin
      state    <= state_next;
      freq_sel <= sel_next;
      err      <= accept && req_bad;
      if (accept && !req_bad) begin
        target_idx <= req_freq;
        target_sel <= freq_encode(req_freq);
      end
      // cur_freq flips on entry to FINISH so it reads the target during DONE.
      if ((state == ST_STEP) && (diff == 3'b000)) cur_freq <= target_idx;
    end
  end

  freqchng_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .count    (timer_count),
    .expire   (timer_expire)
  );

endmodule

// File: tb/tb_freqchng_ctrl.sv
// Directed bench for freqchng_ctrl with SETTLE_CYCLES=4, RESET_FREQ=2.
module tb_freqchng_ctrl;
  import freqchng_pkg::*;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_freq;
  logic       req_ready;
  logic [2:0] freq_sel;
  logic [2:0] cur_freq;
  logic       busy;
  logic       done;
  logic       err;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  freqchng_ctrl #(.SETTLE_CYCLES(4), .RESET_FREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_freq  (req_freq),
    .req_ready (req_ready),
    .freq_sel  (freq_sel),
    .cur_freq  (cur_freq),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge.
  task automatic do_req(input logic [2:0] idx);
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_freq  = idx;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after an accepting edge; follows the sequence until DONE.
  task automatic wait_done(input string tag, input int exp_lat, input logic [2:0] prev_idx,
                           input logic [2:0] exp_idx, input logic [2:0] exp_sel,
                           input logic [11:0] exp_seq, input int n_seq);
    logic [2:0] prev;
    int last_change;
    int nseen;
    bit got_done;
    check($sformatf("%s_busy_after_accept", tag), 32'(busy), 32'd1);
    check($sformatf("%s_ready_low", tag), 32'(req_ready), 32'd0);
    prev = freq_sel;
    last_change = 0;
    nseen = 0;
    got_done = 0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      @(posedge clk);
      #1;
      if (freq_sel !== prev) begin
        check($sformatf("%s_one_bit", tag), 32'($countones(freq_sel ^ prev)), 32'd1);
        if (nseen < 4)
          check($sformatf("%s_seq%0d", tag, nseen), 32'(freq_sel), 32'(exp_seq[3*nseen +: 3]));
        if (last_change != 0)
          check($sformatf("%s_spacing", tag), 32'((c - last_change) >= 5), 32'd1);
        last_change = c;
        nseen++;
        prev = freq_sel;
      end
      if (done) begin
        got_done = 1;
        check($sformatf("%s_latency", tag), 32'(c), 32'(exp_lat));
        check($sformatf("%s_cur_freq", tag), 32'(cur_freq), 32'(exp_idx));
        check($sformatf("%s_freq_sel", tag), 32'(freq_sel), 32'(exp_sel));
        check($sformatf("%s_n_changes", tag), 32'(nseen), 32'(n_seq));
        check($sformatf("%s_no_err", tag), 32'(err), 32'd0);
      end else begin
        check($sformatf("%s_cur_hold", tag), 32'(cur_freq), 32'(prev_idx));
      end
    end
    if (!got_done) check($sformatf("%s_done_timeout", tag), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s_busy_clear", tag), 32'(busy), 32'd0);
    check($sformatf("%s_ready_back", tag), 32'(req_ready), 32'd1);
  endtask

  task automatic err_req(input logic [2:0] idx, input logic [2:0] exp_idx, input logic [2:0] exp_sel);
    do_req(idx);
    check("err_pulse", 32'(err), 32'd1);
    check("err_no_done", 32'(done), 32'd0);
    check("err_ready", 32'(req_ready), 32'd1);
    check("err_sel_kept", 32'(freq_sel), 32'(exp_sel));
    check("err_cur_kept", 32'(cur_freq), 32'(exp_idx));
    @(posedge clk);
    #1;
    check("err_one_cycle", 32'(err), 32'd0);
    check("err_state_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_freq = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq_sel", 32'(freq_sel), 32'b010);
    check("rst_cur_freq", 32'(cur_freq), 32'd2);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // first edge after reset release accepts the request
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    req_freq = 3'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done("r2to0", 6, 3'd2, 3'd0, 3'b000, {9'b0, 3'b000}, 1);

    do_req(3'd5);
    wait_done("r0to5", 11, 3'd0, 3'd5, 3'b101, {6'b0, 3'b101, 3'b001}, 2);
    do_req(3'd0);
    wait_done("r5to0", 11, 3'd5, 3'd0, 3'b000, {6'b0, 3'b000, 3'b100}, 2);
    do_req(3'd3);
    wait_done("r0to3", 11, 3'd0, 3'd3, 3'b011, {6'b0, 3'b011, 3'b001}, 2);
    do_req(3'd4);
    wait_done("r3to4", 16, 3'd3, 3'd4, 3'b100, {3'b0, 3'b100, 3'b000, 3'b010}, 3);
    do_req(3'd4);
    wait_done("r4to4", 1, 3'd4, 3'd4, 3'b100, 12'b0, 0);

    err_req(3'd6, 3'd4, 3'b100);
    err_req(3'd7, 3'd4, 3'b100);

    // valid held high with a new index while busy: ignored until ready returns
    do_req(3'd1);
    req_valid = 1'b1;
    req_freq = 3'd0;
    wait_done("r4to1_held", 11, 3'd4, 3'd1, 3'b001, {6'b0, 3'b001, 3'b101}, 2);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("held_accepted", 32'(busy), 32'd1);
    wait_done("r1to0_held", 6, 3'd1, 3'd0, 3'b000, {9'b0, 3'b000}, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("held_once_idle", 32'(busy), 32'd0);
    end

    // reset in the middle of a sequence
    do_req(3'd5);
    repeat (3) @(posedge clk);
    #1;
    check("mid_sel_stepped", 32'(freq_sel), 32'b001);
    check("mid_state_settle", 32'(dbg_state), 32'(ST_SETTLE));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", 32'(freq_sel), 32'b010);
    check("mid_rst_cur", 32'(cur_freq), 32'd2);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_done", 32'(done), 32'd0);
      check("mid_rst_sel_hold", 32'(freq_sel), 32'b010);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    req_freq = 3'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done("r2to2", 1, 3'd2, 3'd2, 3'b010, 12'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freqchng_ctrl.md
FREQCHNG_CTRL -- requirements
Module: freqchng_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, range 1..255: idle cycles held after each FREQ_SEL bit change.
REQ-002 Parameter RESET_FREQ, default 0, range 0..5: frequency index selected out of reset.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 REQ_VALID  input  1  frequency-change request strobe.
REQ-006 REQ_FREQ  input  3  requested frequency index, 0..5.
REQ-007 REQ_READY  output  1  high when a request can be accepted.
REQ-008 FREQ_SEL  output  3  registered select to the BUFGMUX tree (bit0 first stage, bit1 second stage, bit2 output stage).
REQ-009 CUR_FREQ  output  3  index currently applied and settled.
REQ-010 BUSY  output  1  high while a change sequence is in progress.
REQ-011 DONE  output  1  one-cycle pulse on request completion.
REQ-012 ERR  output  1  one-cycle pulse on rejected request.

Function
REQ-013 Encoding: index 0..3 -> FREQ_SEL = index; 4 -> 3'b100; 5 -> 3'b101; FREQ_SEL[1] is always 0 when FREQ_SEL[2] is 1.
REQ-014 A request is accepted on a rising edge with REQ_VALID=1 and REQ_READY=1; REQ_READY is 1 only in state IDLE.
REQ-015 States: IDLE, STEP, SETTLE, FINISH; an ERR pulse is issued from IDLE directly, with no state change.
REQ-016 IDLE: on accept with REQ_FREQ > 5 -> ERR=1 next cycle, stay IDLE, FREQ_SEL/CUR_FREQ unchanged.
REQ-017 IDLE: on valid accept, latch target encoding; go STEP; BUSY=1 from the next cycle until FINISH exits.
REQ-018 STEP: update exactly one differing FREQ_SEL bit, lowest bit index first (bit0, then bit1, then bit2); go SETTLE with counter loaded to SETTLE_CYCLES; if no bits differ, go FINISH.
REQ-019 SETTLE: decrement the counter each cycle, with FREQ_SEL held; at counter 1, go STEP.
REQ-020 FINISH: DONE=1 and CUR_FREQ = target for this cycle; next state IDLE, BUSY=0.
REQ-021 Latency: with k differing bits, DONE is asserted exactly 1 + k*(1+SETTLE_CYCLES) cycles after the accepting edge; k=0 (same index) gives 1 cycle.
REQ-022 REQ_VALID/REQ_FREQ while REQ_READY=0 are ignored (not queued); the requester must hold or reissue.
REQ-023 CUR_FREQ holds the previous index throughout a sequence and updates only in FINISH.
REQ-024 FREQ_SEL changes at most one bit per rising edge, never more often than once per 1+SETTLE_CYCLES cycles.
REQ-025 DONE and ERR are never asserted in the same cycle.

Reset
REQ-026 Asserting RST: state IDLE, FREQ_SEL = encoding of RESET_FREQ, CUR_FREQ = RESET_FREQ, counter 0, REQ_READY=1, BUSY=0, DONE=0, ERR=0.
REQ-027 RST asserted mid-sequence aborts it immediately: no DONE is issued and FREQ_SEL returns to the RESET_FREQ encoding.
REQ-028 The first request is accepted on the first rising edge after RST deasserts.

Structure
REQ-029 Shared package freqchng_pkg holds the state encoding, FREQ_IDX_MAX=5, and the index-to-select encoding function used by this block and by benches.
REQ-030 The settle countdown is implemented as sub-module freqchng_settle_timer (load, count, expire), 8-bit counter.
REQ-031 freqchng_ctrl does not instantiate the clock mux; the enclosing level connects FREQ_SEL to the mux select.

Verification
REQ-032 Reset with RESET_FREQ=2 -> FREQ_SEL=3'b010, CUR_FREQ=2, REQ_READY=1; RST pulsed mid-sequence -> FREQ_SEL back to 3'b010, no DONE.
REQ-033 SETTLE_CYCLES=4, 0->5 -> FREQ_SEL 000, then 001, then 101; DONE exactly 11 cycles after accept; CUR_FREQ=5.
REQ-034 SETTLE_CYCLES=4, 3->4 -> FREQ_SEL 011, then 010, then 000, then 100; DONE 16 cycles after accept.
REQ-035 Request equal to CUR_FREQ -> DONE 1 cycle after accept; FREQ_SEL unchanged.
REQ-036 REQ_FREQ=6 and then 7 -> ERR pulse each; no DONE; FREQ_SEL/CUR_FREQ unchanged.
REQ-037 REQ_VALID held high during a busy sequence with a different index -> that request is ignored until READY returns, then accepted once.
